stdp_array: RTL and testbench

STDP_ARRAY -- requirements
Module: stdp_array

---
 rtl/stdp_array.sv | 128 ++++++++++++
 tb/tb_stdp_array.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_array.sv
// Spike-timing-dependent plasticity array: N_PRE LIF input neurons feed one LIF
// output neuron through learned weights, with pair-based STDP updates.
module stdp_array #(
  parameter int N_PRE      = 4,
  parameter int W          = 8,
  parameter int TW         = 4,
  parameter int THRESH     = 200,
  parameter int LEAK_SHIFT = 2,
  parameter int A_PLUS     = 8,
  parameter int A_MINUS    = 8,
  parameter int W_INIT     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 learn_en,
  input  logic [N_PRE*W-1:0]   cur_in,
  input  logic [W-1:0]         teach_in,
  output logic [N_PRE-1:0]     pre_spike,
  output logic                 post_spike,
  output logic [W-1:0]         post_state,
  output logic [N_PRE*W-1:0]   weight_flat,
  output logic [N_PRE-1:0]     w_upd
);

  localparam int              NN     = N_PRE + 1;
  localparam int              POST   = N_PRE;
  localparam int              SW     = W + $clog2(NN) + 1;
  localparam logic [TW-1:0]   TMAX   = '1;
  localparam logic [W-1:0]    WMAX   = '1;
  localparam logic [W-1:0]    THR    = W'(THRESH);
  localparam logic [W-1:0]    W_RST  = W'(W_INIT);

  logic [NN-1:0][W-1:0]     v_q, v_d;
  logic [NN-1:0]            spike_q, spike_d;
  logic [NN-1:0][TW-1:0]    t_q, t_d;
  logic [N_PRE-1:0][W-1:0]  w_q, w_d;
  logic [N_PRE-1:0]         w_upd_q, w_upd_d;

  logic [NN-1:0][W-1:0]     i_cur;
  logic [SW-1:0]            sum_post;
  logic [W:0]               v_sum;
  logic [W-1:0]             v_sat;
  int                       delta;
  int                       w_new;

  // Input currents: external per channel, weighted registered pre-spikes for the post neuron.
  always_comb begin
    sum_post = SW'(teach_in);
    for (int i = 0; i < N_PRE; i++) begin
      i_cur[i] = cur_in[i*W +: W];
      if (spike_q[i]) sum_post = sum_post + SW'(w_q[i]);
    end
    i_cur[POST] = (sum_post > SW'(WMAX)) ? WMAX : sum_post[W-1:0];
  end

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    v_d     = v_q;
    spike_d = '0;
    t_d     = t_q;
    w_d     = w_q;
    w_upd_d = '0;
    v_sum   = '0;
    v_sat   = '0;
    delta   = 0;
    w_new   = 0;

    if (en) begin
      for (int n = 0; n < NN; n++) begin
        v_sum = {1'b0, v_q[n] - (v_q[n] >> LEAK_SHIFT)} + {1'b0, i_cur[n]};
        v_sat = v_sum[W] ? WMAX : v_sum[W-1:0];
        if (v_sat >= THR) begin
          spike_d[n] = 1'b1;
          v_d[n]     = '0;
        end else begin
          v_d[n]     = v_sat;
        end
        if (spike_q[n])         t_d[n] = '0;
        else if (t_q[n] != TMAX) t_d[n] = t_q[n] + 1'b1;
      end

      // Weight moves are derived from the current (pre-update) spikes and timers.
      if (learn_en) begin
        for (int i = 0; i < N_PRE; i++) begin
          if (spike_q[POST] && !spike_q[i] && t_q[i] != TMAX) begin
            delta = A_PLUS - int'(t_q[i]);
            if (delta < 0) delta = 0;
            w_new = int'(w_q[i]) + delta;
            if (w_new > int'(WMAX)) w_new = int'(WMAX);
            w_d[i] = W'(w_new);
          end else if (spike_q[i] && !spike_q[POST] && t_q[POST] != TMAX) begin
            delta = A_MINUS - int'(t_q[POST]);
            if (delta < 0) delta = 0;
            w_new = int'(w_q[i]) - delta;
            if (w_new < 0) w_new = 0;
            w_d[i] = W'(w_new);
          end
          w_upd_d[i] = (w_d[i] != w_q[i]);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      spike_q <= '0;
      t_q     <= {NN{TMAX}};
      w_q     <= {N_PRE{W_RST}};
      w_upd_q <= '0;
    end else begin
      v_q     <= v_d;
      spike_q <= spike_d;
      t_q     <= t_d;
      w_q     <= w_d;
      w_upd_q <= w_upd_d;
    end
  end

  assign pre_spike   = spike_q[N_PRE-1:0];
  assign post_spike  = spike_q[POST];
  assign post_state  = v_q[POST];
  assign weight_flat = w_q;
  assign w_upd       = w_upd_q;

endmodule

// File: tb/tb_stdp_array.sv
// Scoreboarded bench for stdp_array: two instances (default and saturating W_INIT)
// run in lockstep against a plain-arithmetic reference model.
module tb_stdp_array;

  typedef struct packed {
    logic [3:0]  pre;
    logic        post;
    logic [7:0]  state;
    logic [31:0] wf;
    logic [3:0]  upd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst, en, learn_en;
  logic [31:0] cur_in;
  logic [7:0]  teach_in;

  logic [3:0]  pre_a, pre_b, upd_a, upd_b;
  logic        post_a, post_b;
  logic [7:0]  state_a, state_b;
  logic [31:0] wf_a, wf_b;

  int checks = 0;
  int errors = 0;

  obs_t exp_a[$];
  obs_t exp_b[$];

  // Reference state per instance: membranes, spikes, timers (index 4 = post), weights, pulses.
  int mv[2][5], ms[2][5], mt[2][5], mw[2][4], mu[2][4];

  always #5 clk = ~clk;

  stdp_array dut_a (
    .clk(clk), .rst(rst), .en(en), .learn_en(learn_en), .cur_in(cur_in), .teach_in(teach_in),
    .pre_spike(pre_a), .post_spike(post_a), .post_state(state_a), .weight_flat(wf_a), .w_upd(upd_a)
  );

  stdp_array #(.W_INIT(250)) dut_b (
    .clk(clk), .rst(rst), .en(en), .learn_en(learn_en), .cur_in(cur_in), .teach_in(teach_in),
    .pre_spike(pre_b), .post_spike(post_b), .post_state(state_b), .weight_flat(wf_b), .w_upd(upd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l,
                            input logic [31:0] cur, input logic [7:0] teach);
    for (int j = 0; j < 2; j++) begin
      if (r) begin
        for (int n = 0; n < 5; n++) begin mv[j][n] = 0; ms[j][n] = 0; mt[j][n] = 15; end
        for (int i = 0; i < 4; i++) begin mw[j][i] = (j == 0) ? 64 : 250; mu[j][i] = 0; end
      end else if (!e) begin
        for (int n = 0; n < 5; n++) ms[j][n] = 0;
        for (int i = 0; i < 4; i++) mu[j][i] = 0;
      end else begin
        int nw[4];
        int ic[5];
        int s;
        int vn;
        for (int i = 0; i < 4; i++) begin
          nw[i] = mw[j][i];
          if (l && ms[j][4] == 1 && ms[j][i] == 0 && mt[j][i] < 15)
            nw[i] = mw[j][i] + ((8 - mt[j][i] > 0) ? 8 - mt[j][i] : 0);
          else if (l && ms[j][i] == 1 && ms[j][4] == 0 && mt[j][4] < 15)
            nw[i] = mw[j][i] - ((8 - mt[j][4] > 0) ? 8 - mt[j][4] : 0);
          if (nw[i] > 255) nw[i] = 255;
          if (nw[i] < 0) nw[i] = 0;
        end
        s = int'(teach);
        for (int i = 0; i < 4; i++) begin
          ic[i] = int'(cur[i*8 +: 8]);
          if (ms[j][i] == 1) s += mw[j][i];
        end
        ic[4] = (s > 255) ? 255 : s;
        for (int n = 0; n < 5; n++) begin
          vn = mv[j][n] - mv[j][n] / 4 + ic[n];
          if (vn > 255) vn = 255;
          mt[j][n] = (ms[j][n] == 1) ? 0 : ((mt[j][n] < 15) ? mt[j][n] + 1 : 15);
          if (vn >= 200) begin ms[j][n] = 1; mv[j][n] = 0; end
          else begin ms[j][n] = 0; mv[j][n] = vn; end
        end
        for (int i = 0; i < 4; i++) begin
          mu[j][i] = (nw[i] != mw[j][i]) ? 1 : 0;
          mw[j][i] = nw[i];
        end
      end
    end
  endtask

  function automatic obs_t model_obs(input int j);
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      o.pre[i]          = ms[j][i][0];
      o.upd[i]          = mu[j][i][0];
      o.wf[i*8 +: 8]    = mw[j][i][7:0];
    end
    o.post  = ms[j][4][0];
    o.state = mv[j][4][7:0];
    return o;
  endfunction

  // Apply one cycle of stimulus, record the model's expected response, advance.
  task automatic step(input bit r, input bit e, input bit l,
                      input logic [31:0] c, input logic [7:0] t);
    rst = r; en = e; learn_en = l; cur_in = c; teach_in = t;
    model_step(r, e, l, c, t);
    exp_a.push_back(model_obs(0));
    exp_b.push_back(model_obs(1));
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
  endtask

  // Pre spike on ch0 at k, teach at k+2, post spike at k+3; returns showing cycle k+4.
  task automatic pot_seq(input bit l);
    step(1'b0, 1'b1, l, 32'd200, 8'd0);
    step(1'b0, 1'b1, l, 32'd0, 8'd0);
    step(1'b0, 1'b1, l, 32'd0, 8'd0);
    step(1'b0, 1'b1, l, 32'd0, 8'd255);
    check("pot_post_spike", {31'd0, post_a}, 32'd1);
    step(1'b0, 1'b1, l, 32'd0, 8'd0);
  endtask

  // Scoreboard monitor: each cycle the DUTs present outputs, compare with the oldest expectation.
  always @(negedge clk) begin
    obs_t e;
    if (exp_a.size() != 0) begin
      e = exp_a.pop_front();
      check("a_pre",   {28'd0, pre_a},   {28'd0, e.pre});
      check("a_post",  {31'd0, post_a},  {31'd0, e.post});
      check("a_state", {24'd0, state_a}, {24'd0, e.state});
      check("a_wf",    wf_a,             e.wf);
      check("a_upd",   {28'd0, upd_a},   {28'd0, e.upd});
    end
    if (exp_b.size() != 0) begin
      e = exp_b.pop_front();
      check("b_pre",   {28'd0, pre_b},   {28'd0, e.pre});
      check("b_post",  {31'd0, post_b},  {31'd0, e.post});
      check("b_state", {24'd0, state_b}, {24'd0, e.state});
      check("b_wf",    wf_b,             e.wf);
      check("b_upd",   {28'd0, upd_b},   {28'd0, e.upd});
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; learn_en = 1'b0; cur_in = '0; teach_in = '0;
    @(negedge clk);
    #1;

    step(1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
    check("rst_wf_a",    wf_a, {4{8'd64}});
    check("rst_wf_b",    wf_b, {4{8'd250}});
    check("rst_state",   {24'd0, state_a}, 32'd0);
    check("rst_spikes",  {27'd0, post_a, pre_a}, 32'd0);
    check("rst_upd",     {28'd0, upd_a}, 32'd0);

    // Single-cycle firing on ch0, then silence.
    step(1'b0, 1'b1, 1'b1, 32'd200, 8'd0);
    check("fire_once", {28'd0, pre_a}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    check("fire_gone", {28'd0, pre_a}, 32'd0);
    idle(16);

    // Potentiation: 64 + 8 - 2; the W_INIT=250 copy clips at 255.
    pot_seq(1'b1);
    check("pot_w0",   {24'd0, wf_a[7:0]}, 32'd70);
    check("pot_upd",  {28'd0, upd_a}, 32'd1);
    check("sat_w0_b", {24'd0, wf_b[7:0]}, 32'd255);
    idle(16);

    // Immediate repeat: saturated weight cannot move, so no pulse.
    pot_seq(1'b1);
    check("pot2_w0",   {24'd0, wf_a[7:0]}, 32'd76);
    check("sat2_w0_b", {24'd0, wf_b[7:0]}, 32'd255);
    check("sat2_upd_b", {28'd0, upd_b}, 32'd0);
    idle(16);

    // Depression: post at k, pre on ch1 at k+3 -> 64 - 6.
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd255);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 32'd200 << 8, 8'd0);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    check("dep_w1", {24'd0, wf_a[15:8]}, 32'd58);
    check("dep_upd", {28'd0, upd_a}, 32'd2);
    idle(16);

    // Coincident pre (ch2) and post spikes leave weight[2] untouched.
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd255);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 32'd200 << 16, 8'd255);
    check("coin_both", {27'd0, post_a, pre_a}, 32'h14);
    step(1'b0, 1'b1, 1'b1, 32'd0, 8'd0);
    check("coin_w2", {24'd0, wf_a[23:16]}, 32'd64);
    check("coin_upd", {28'd0, upd_a}, 32'd0);
    idle(16);

    // Learning frozen: the same pairing leaves weight[0] alone.
    pot_seq(1'b0);
    check("frozen_w0", {24'd0, wf_a[7:0]}, 32'd76);

    // Enable low: spikes and pulses drop, state holds.
    step(1'b0, 1'b1, 1'b1, 32'hC8C8C8C8, 8'd255);
    step(1'b0, 1'b0, 1'b1, 32'hC8C8C8C8, 8'd255);
    check("en_off_spikes", {27'd0, post_a, pre_a}, 32'd0);

    // Randomised traffic with occasional reset and enable/learn toggles.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] c;
      logic [7:0]  t;
      for (int i = 0; i < 4; i++)
        c[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255))
                                                  : 8'($urandom_range(0, 60));
      t = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 20));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 4) != 0), c, t);
    end

    for (int k = 0; k < 10 && (exp_a.size() != 0 || exp_b.size() != 0); k++) @(negedge clk);
    #1;
    check("drain", exp_a.size() + exp_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
